match_state_controller: RTL and testbench

//  Pong match sequencer; sits directly upstream of the game-over display stage.

---
 rtl/match_if.sv | 27 ++
 rtl/match_state_controller.sv | 165 ++++++++++++++++
 tb/tb_match_state_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/match_if.sv
// Match controller bus: per-frame and miss stimulus in, score/loss/play status out.
//   master : the surrounding game logic (drives frame_tick, start, missA, missB)
//   slave  : match_state_controller (drives scoreA, scoreB, lossA, lossB, play_en, serve)
interface match_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic               missA;
    logic               missB;
    logic [SCORE_W-1:0] scoreA;
    logic [SCORE_W-1:0] scoreB;
    logic               lossA;
    logic               lossB;
    logic               play_en;
    logic               serve;

    modport master (
        output frame_tick, start, missA, missB,
        input  scoreA, scoreB, lossA, lossB, play_en, serve
    );

    modport slave (
        input  frame_tick, start, missA, missB,
        output scoreA, scoreB, lossA, lossB, play_en, serve
    );
endinterface

// File: rtl/match_state_controller.sv
// Pong match sequencer: counts points from ball-miss pulses and sequences
// IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER), frame-timed via frame_tick.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   bus       : match_if.slave
//               in  frame_tick (1/frame pulse), start (level), missA/missB (pulses)
//               out scoreA/scoreB, lossA/lossB (held through OVER), play_en, serve (pulse)
// All outputs are registered.
// Optional feature macro: AUTO_RESTART_EN -- OVER returns to IDLE by itself once
// the game-over hold has elapsed (scores kept for display, loss flags cleared).
module match_state_controller #(
    parameter int unsigned WIN_SCORE    = 5,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned HOLD_FRAMES  = 180
) (
    input  logic    clk,
    input  logic    rst,
    match_if.slave  bus
);

    localparam int unsigned CNT_MAX = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   HOLD_CNT   = CNT_W'(HOLD_FRAMES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic               loss_a_q, loss_a_d;
    logic               loss_b_q, loss_b_d;
    logic               play_en_q, play_en_d;
    logic               serve_q, serve_d;
    logic               start_q;
    logic               start_edge;
    logic               hold_done;

    assign start_edge = bus.start & ~start_q;
    assign hold_done  = (cnt_q == HOLD_CNT);

    // State, counter and registered outputs; start_q resets high so a held button is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            score_a_q <= '0;
            score_b_q <= '0;
            loss_a_q  <= 1'b0;
            loss_b_q  <= 1'b0;
            play_en_q <= 1'b0;
            serve_q   <= 1'b0;
            start_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            loss_a_q  <= loss_a_d;
            loss_b_q  <= loss_b_d;
            play_en_q <= play_en_d;
            serve_q   <= serve_d;
            start_q   <= bus.start;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        loss_a_d  = loss_a_q;
        loss_b_d  = loss_b_q;
        serve_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d   = SERVE;
                    score_a_d = '0;
                    score_b_d = '0;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = PLAY;
                        serve_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                // Simultaneous misses are a replay with no point awarded
                if (bus.missA && bus.missB) begin
                    state_d = SERVE;
                end else if (bus.missA) begin
                    if (score_b_q != WIN) score_b_d = score_b_q + SCORE_W'(1);
                    state_d = POINT;
                end else if (bus.missB) begin
                    if (score_a_q != WIN) score_a_d = score_a_q + SCORE_W'(1);
                    state_d = POINT;
                end
            end
            POINT: begin
                if (score_b_q == WIN) begin
                    state_d  = OVER;
                    loss_a_d = 1'b1;
                end else if (score_a_q == WIN) begin
                    state_d  = OVER;
                    loss_b_d = 1'b1;
                end else begin
                    state_d = SERVE;
                end
            end
            OVER: begin
                if (hold_done && start_edge) begin
                    state_d   = SERVE;
                    score_a_d = '0;
                    score_b_d = '0;
                    loss_a_d  = 1'b0;
                    loss_b_d  = 1'b0;
                end
`ifdef AUTO_RESTART_EN
                else if (hold_done) begin
                    state_d  = IDLE;
                    loss_a_d = 1'b0;
                    loss_b_d = 1'b0;
                end
`endif
                else if (bus.frame_tick && !hold_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter restarts on every state entry
        if (state_d != state_q) cnt_d = '0;

        play_en_d = (state_d == PLAY);
    end

    assign bus.scoreA  = score_a_q;
    assign bus.scoreB  = score_b_q;
    assign bus.lossA   = loss_a_q;
    assign bus.lossB   = loss_b_q;
    assign bus.play_en = play_en_q;
    assign bus.serve   = serve_q;

endmodule

// File: tb/tb_match_state_controller.sv
// Testbench for match_state_controller: directed scenarios plus randomized
// stimulus, every cycle compared against a rule-level match model.
module tb_match_state_controller;

    localparam int unsigned WIN = 3;
    localparam int unsigned SW  = 4;
    localparam int unsigned SF  = 60;
    localparam int unsigned HF  = 180;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_POINT = 3;
    localparam int PH_OVER  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    match_if #(.SCORE_W(SW)) ifc ();

    match_state_controller #(
        .WIN_SCORE    (WIN),
        .SCORE_W      (SW),
        .SERVE_FRAMES (SF),
        .HOLD_FRAMES  (HF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;

    // Model of the match: phase, scores, losers, ticks seen in the current phase
    int m_phase;
    int m_sa, m_sb, m_ticks;
    bit m_la, m_lb, m_serve, m_sq;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_sa = 0; m_sb = 0; m_ticks = 0;
        m_la = 0; m_lb = 0; m_serve = 0;
        m_sq = 1;
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_ticks = 0;
    endtask

    task automatic model_step(input bit ft, input bit st, input bit ma, input bit mb);
        bit edge_s;
        if (rst) begin
            model_reset();
        end else begin
            edge_s  = st && !m_sq;
            m_sq    = st;
            m_serve = 0;
            case (m_phase)
                PH_IDLE: if (edge_s) begin m_sa = 0; m_sb = 0; enter(PH_SERVE); end
                PH_SERVE: if (ft) begin
                    m_ticks++;
                    if (m_ticks == SF) begin m_serve = 1; enter(PH_PLAY); end
                end
                PH_PLAY: begin
                    if (ma && mb) enter(PH_SERVE);
                    else if (ma) begin m_sb = (m_sb < WIN) ? m_sb + 1 : m_sb; enter(PH_POINT); end
                    else if (mb) begin m_sa = (m_sa < WIN) ? m_sa + 1 : m_sa; enter(PH_POINT); end
                end
                PH_POINT: begin
                    if (m_sb == WIN) begin m_la = 1; enter(PH_OVER); end
                    else if (m_sa == WIN) begin m_lb = 1; enter(PH_OVER); end
                    else enter(PH_SERVE);
                end
                default: begin
                    if (m_ticks == HF && edge_s) begin
                        m_sa = 0; m_sb = 0; m_la = 0; m_lb = 0;
                        enter(PH_SERVE);
                    end
`ifdef AUTO_RESTART_EN
                    else if (m_ticks == HF) begin
                        m_la = 0; m_lb = 0;
                        enter(PH_IDLE);
                    end
`endif
                    else if (ft && m_ticks < HF) m_ticks++;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("scoreA",  32'(ifc.scoreA),  32'(m_sa));
        check_eq("scoreB",  32'(ifc.scoreB),  32'(m_sb));
        check_eq("lossA",   32'(ifc.lossA),   32'(m_la));
        check_eq("lossB",   32'(ifc.lossB),   32'(m_lb));
        check_eq("play_en", 32'(ifc.play_en), 32'(m_phase == PH_PLAY));
        check_eq("serve",   32'(ifc.serve),   32'(m_serve));
    endtask

    // One clock: drive on the falling edge, model on the rising edge, compare 1 time unit later
    task automatic step(input bit ft, input bit st, input bit ma, input bit mb);
        @(negedge clk);
        ifc.frame_tick = ft;
        ifc.start      = st;
        ifc.missA      = ma;
        ifc.missB      = mb;
        @(posedge clk);
        model_step(ft, st, ma, mb);
        #1;
        compare_all();
    endtask

    // Reset asserted between clock edges must clear outputs without a clock
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_scoreA",  32'(ifc.scoreA),  0);
        check_eq("rst_scoreB",  32'(ifc.scoreB),  0);
        check_eq("rst_lossA",   32'(ifc.lossA),   0);
        check_eq("rst_lossB",   32'(ifc.lossB),   0);
        check_eq("rst_play_en", 32'(ifc.play_en), 0);
        check_eq("rst_serve",   32'(ifc.serve),   0);
        model_reset();
        step(0, ifc.start, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Feed frame ticks until the DUT is playing, with a cycle budget
    task automatic run_to_play(input bit st);
        int n;
        n = 0;
        while (ifc.play_en !== 1'b1 && n < 4 * SF) begin
            step(1, st, 0, 0);
            n++;
        end
        check_eq("reach_play", 32'(ifc.play_en), 1);
    endtask

    initial begin
        rst = 1'b1;
        ifc.frame_tick = 1'b0;
        ifc.start      = 1'b1;
        ifc.missA      = 1'b0;
        ifc.missB      = 1'b0;
        model_reset();
        repeat (3) step(0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Start held through reset release is not an edge; misses in IDLE do nothing
        for (int i = 0; i < 8; i++) step(i[0], 1, 0, 1);
        check_eq("idle_scoreA", 32'(ifc.scoreA), 0);

        // Start a game, serve timing, then B wins with three missA
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int p = 0; p < 3; p++) begin
            run_to_play(1);
            step(0, 1, 1, 0);
            step(0, 1, 0, 0);
        end
        step(0, 1, 0, 0);
        check_eq("over_lossA", 32'(ifc.lossA), 1);
        check_eq("over_scoreB", 32'(ifc.scoreB), WIN);

        // Start edge during the game-over hold is ignored
        for (int i = 0; i < 100; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check_eq("hold_ignore_lossA", 32'(ifc.lossA), 1);
        for (int i = 0; i < 100; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);

        // Simultaneous miss replays the serve without scoring
        run_to_play(1);
        step(0, 1, 0, 1);
        run_to_play(1);
        step(0, 1, 1, 1);
        check_eq("replay_scoreA", 32'(ifc.scoreA), 1);
        run_to_play(1);

        async_reset();

        // Randomized play
        for (int i = 0; i < 20000; i++) begin
            bit st;
            st = ifc.start;
            if ($urandom_range(0, 29) == 0) st = ~st;
            step($urandom_range(0, 2) == 0, st,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
            if (i == 9000) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
